cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter_pkg.sv | 16 +
 rtl/cpu_mem_arbiter.sv | 97 +++++++++
 tb/tb_cpu_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared CPU types and constants for the memory arbiter
package cpu_mem_arbiter_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 8;

    localparam logic [2:0] PHASE_FETCH  = 3'd0;
    localparam logic [2:0] PHASE_RETIRE = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DBG_ACC = 2'd1,
        DBG_ACK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares one memory port between the CPU and a debug/loader requester
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cpu_phase,
    input  logic          cpu_halt,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state;
    logic          token;
    logic          token_eff;
    logic          grant;
    logic [DW-1:0] rdata_q;

    // A halted CPU never retires, so halt stands in for the token.
    assign token_eff = token | cpu_halt;
    assign grant     = !rst && (state == IDLE) && dbg_req && token_eff &&
                       ((cpu_phase == PHASE_FETCH) || cpu_halt);
    assign cpu_stall = !rst && (grant || (state != IDLE));
    assign dbg_ack   = !rst && (state == DBG_ACK);

    // Read data arrives during the ack cycle; forward it so it is valid with dbg_ack.
    assign dbg_rdata = (dbg_ack && !dbg_we) ? mem_rdata : rdata_q;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        case (state)
            DBG_ACC: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_rd    = !dbg_we;
                mem_wr    = dbg_we;
            end
            DBG_ACK: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_rd    = 1'b0;
                mem_wr    = 1'b0;
            end
            default: ;
        endcase
        if (rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            token   <= 1'b1;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE:    if (grant) state <= DBG_ACC;
                DBG_ACC: state <= DBG_ACK;
                DBG_ACK: begin
                    state <= IDLE;
                    if (!dbg_we) rdata_q <= mem_rdata;
                end
                default: state <= IDLE;
            endcase

            if (cpu_halt)
                token <= 1'b1;
            else if (grant)
                token <= 1'b0;
            else if ((cpu_phase == PHASE_RETIRE) && !cpu_stall)
                token <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    cpu_phase = 3'd0;
    logic          cpu_halt, cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          wipe;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_phase(cpu_phase), .cpu_halt(cpu_halt),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    // Memory seen by the DUT: one-cycle read latency, write on the strobe.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < (1<<AW); i++) env_mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_rd) mem_rdata <= env_mem[mem_addr];
            if (mem_wr) env_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy counts cycles left in a debug transaction.
    int            busy = 0;
    bit            tok = 1'b1;
    bit            model_on = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_wdata = '0;
    bit            t_we = 1'b0;
    bit            m_grant, e_stall, e_ack, e_rd, e_wr;
    logic [DW-1:0] e_rdata;
    bit            s_rst, s_wipe, s_grant, s_estall, s_stall, s_halt, s_cpu_wr, s_dbg_we;
    logic [2:0]    s_phase;
    logic [AW-1:0] s_cpu_addr, s_dbg_addr;
    logic [DW-1:0] s_cpu_wdata, s_dbg_wdata;

    initial begin
        forever begin
            @(negedge clk);
            m_grant = 1'b0;
            e_stall = 1'b0;
            if (model_on) begin
                m_grant = !rst && busy == 0 && dbg_req && (tok || cpu_halt) &&
                          (cpu_phase == 3'd0 || cpu_halt);
                e_stall = !rst && (m_grant || busy != 0);
                e_ack   = !rst && busy == 1;
                if (rst)            begin e_rd = 1'b0;   e_wr = 1'b0;   end
                else if (busy == 2) begin e_rd = !t_we;  e_wr = t_we;   end
                else if (busy == 1) begin e_rd = 1'b0;   e_wr = 1'b0;   end
                else                begin e_rd = cpu_rd; e_wr = cpu_wr; end
                e_rdata = (e_ack && !t_we) ? ref_mem[t_addr] : m_rdata;
                chk("cyc_stall", 32'(cpu_stall), 32'(e_stall));
                chk("cyc_ack",   32'(dbg_ack),   32'(e_ack));
                chk("cyc_mem_rd", 32'(mem_rd),   32'(e_rd));
                chk("cyc_mem_wr", 32'(mem_wr),   32'(e_wr));
                chk("cyc_rdata", 32'(dbg_rdata), 32'(e_rdata));
                if (!rst && busy != 1) begin
                    chk("cyc_mem_addr",  32'(mem_addr),  32'(busy == 2 ? t_addr : cpu_addr));
                    chk("cyc_mem_wdata", 32'(mem_wdata), 32'(busy == 2 ? t_wdata : cpu_wdata));
                end
            end
            s_rst = rst; s_wipe = wipe; s_grant = m_grant; s_estall = e_stall;
            s_stall = cpu_stall; s_halt = cpu_halt; s_phase = cpu_phase;
            s_cpu_wr = cpu_wr; s_cpu_addr = cpu_addr; s_cpu_wdata = cpu_wdata;
            s_dbg_we = dbg_we; s_dbg_addr = dbg_addr; s_dbg_wdata = dbg_wdata;
            @(posedge clk);
            #1;
            if (s_rst) begin
                busy = 0; tok = 1'b1; m_rdata = '0; model_on = 1'b1;
                if (s_wipe) for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
            end else begin
                if (busy == 2 && t_we) ref_mem[t_addr] = t_wdata;
                if (busy == 0 && s_cpu_wr) ref_mem[s_cpu_addr] = s_cpu_wdata;
                if (busy == 1) begin
                    if (!t_we) m_rdata = ref_mem[t_addr];
                    busy = 0;
                end else if (busy == 2) begin
                    busy = 1;
                end else if (s_grant) begin
                    busy = 2; t_addr = s_dbg_addr; t_we = s_dbg_we; t_wdata = s_dbg_wdata;
                end
                if (s_halt)                                tok = 1'b1;
                else if (s_grant)                          tok = 1'b0;
                else if (s_phase == 3'd7 && !s_estall)     tok = 1'b1;
            end
            // The CPU's phase counter, frozen by stall or halt.
            if (!s_stall && !s_halt) cpu_phase = cpu_phase + 3'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_phase(input logic [2:0] p);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (cpu_phase == p) ok = 1'b1;
            else step();
        end
        if (!ok) chk("phase_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output int stl, output logic [DW-1:0] rd,
                          output logic [2:0] gph);
        int g = -1;
        bit done = 1'b0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        lat = -1; stl = 0; rd = '0; gph = 3'd0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (cpu_stall) begin
                stl++;
                if (g < 0) begin g = k; gph = cpu_phase; end
            end
            if (dbg_ack) begin
                lat = k - g; rd = dbg_rdata; done = 1'b1;
            end
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
        step();
        dbg_req = 1'b0;
    endtask

    int            lat, stl, acks;
    logic [DW-1:0] rd;
    logic [2:0]    gph;

    initial begin
        rst = 1'b1; wipe = 1'b1;
        cpu_halt = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0; wipe = 1'b0;
        @(negedge clk);
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_ack",   32'(dbg_ack),   32'd0);
        chk("reset_rdata", 32'(dbg_rdata), 32'd0);
        step();

        for (int i = 0; i < 8; i++) begin
            cpu_rd = i[0]; cpu_wr = !i[0];
            cpu_addr = AW'(16 + i); cpu_wdata = DW'(8'h10 + i);
            step();
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Halted CPU: back-to-back write then read of address 5.
        cpu_halt = 1'b1;
        step();
        do_txn(1'b1, 5'd5, 8'hA5, lat, stl, rd, gph);
        chk("halt_wr_latency", 32'(lat), 32'd2);
        chk("halt_wr_stall",   32'(stl), 32'd3);
        do_txn(1'b0, 5'd5, 8'h00, lat, stl, rd, gph);
        chk("halt_rd_latency", 32'(lat), 32'd2);
        chk("halt_rd_stall",   32'(stl), 32'd3);
        chk("halt_rd_data",    32'(rd),  32'hA5);
        cpu_halt = 1'b0;
        step();

        // Running CPU: request at phase 3 waits for phase 0.
        wait_phase(3'd7);
        wait_phase(3'd3);
        do_txn(1'b0, 5'd5, 8'h00, lat, stl, rd, gph);
        chk("run_grant_phase", 32'(gph), 32'd0);
        chk("run_stall",       32'(stl), 32'd3);
        chk("run_latency",     32'(lat), 32'd2);
        chk("run_rd_data",     32'(rd),  32'hA5);
        chk("run_phase_hold",  32'(cpu_phase), 32'd0);
        step();
        chk("run_phase_adv",   32'(cpu_phase), 32'd1);

        // Continuous request: one transaction per 11-cycle instruction.
        wait_phase(3'd7);
        wait_phase(3'd0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd16; dbg_wdata = '0;
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dbg_ack) acks++;
        end
        chk("fair_acks", 32'(acks), 32'd4);
        step();
        dbg_req = 1'b0;

        // CPU write at phase 7 with a debug read of the same address pending.
        wait_phase(3'd7);
        cpu_wr = 1'b1; cpu_addr = 5'd3; cpu_wdata = 8'h3C;
        fork
            do_txn(1'b0, 5'd3, 8'h00, lat, stl, rd, gph);
            begin
                step();
                cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
            end
        join
        chk("cpuwr_grant_phase", 32'(gph), 32'd0);
        chk("cpuwr_rd_data",     32'(rd),  32'h3C);
        chk("cpuwr_mem",         32'(env_mem[3]), 32'h3C);

        // Reset during the access cycle drops the transaction.
        wait_phase(3'd7);
        wait_phase(3'd0);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 8'h77;
        @(negedge clk);
        chk("rst_pre_grant", 32'(cpu_stall), 32'd1);
        step();
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        chk("rst_acc_ack",   32'(dbg_ack), 32'd0);
        chk("rst_acc_wr",    32'(mem_wr),  32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ack",   32'(dbg_ack),   32'd0);
        chk("rst_after_stall", 32'(cpu_stall), 32'd0);
        chk("rst_no_write",    32'(env_mem[9]), 32'd0);
        step();
        do_txn(1'b1, 5'd9, 8'h77, lat, stl, rd, gph);
        chk("retry_latency", 32'(lat), 32'd2);
        do_txn(1'b0, 5'd9, 8'h00, lat, stl, rd, gph);
        chk("retry_rd_data", 32'(rd), 32'h77);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
